// File: rtl/bram_lsu_if.sv
// ---------------------------------------------------------------------------
// bram_lsu_if
// CPU-side request/response bundle of the block-RAM load/store unit.
//   req_valid/req_ready  request handshake, accept = valid & ready
//   req_write            1 = store, 0 = load
//   req_size             00 byte, 01 half, 10/11 word
//   req_signed           sign-extend loads when 1
//   req_addr             byte address (little-endian lanes)
//   req_wdata            store data, right-aligned
//   resp_valid           one-cycle completion pulse, no back-pressure
//   resp_rdata           extended load data, 0 for stores
//   resp_error           misalignment flag
// master = CPU memory stage, slave = LSU.
// ---------------------------------------------------------------------------
interface bram_lsu_if #(
  parameter int ADDR_WIDTH = 11
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_error;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/bram_lsu.sv
// ---------------------------------------------------------------------------
// bram_lsu
// Load/store unit between the CPU memory stage and a single-port, word-wide
// block RAM (1-cycle registered read, no byte enables). Sub-word stores are
// performed as read-modify-write.
// Ports:
//   clock, reset   single clock, synchronous active-high reset
//   bus            bram_lsu_if.slave, request/response bundle
//   ram_enable     RAM port enable
//   write_enable   RAM write strobe
//   ram_address    RAM word address
//   ram_in_data    RAM write data
//   ram_out_data   RAM read data (valid the cycle after an enabled read)
// Build option: define LSU_ALIGN_CHECK_EN to flag misaligned half/word
// accesses with resp_error instead of silently ignoring the low address bits.
// ---------------------------------------------------------------------------
module bram_lsu #(
  parameter int RAM_WIDTH     = 32,
  parameter int RAM_ADDR_BITS = 9,
  parameter int ADDR_WIDTH    = RAM_ADDR_BITS + 2
) (
  input  logic                     clock,
  input  logic                     reset,
  bram_lsu_if.slave                bus,
  output logic                     ram_enable,
  output logic                     write_enable,
  output logic [RAM_ADDR_BITS-1:0] ram_address,
  output logic [RAM_WIDTH-1:0]     ram_in_data,
  input  logic [RAM_WIDTH-1:0]     ram_out_data
);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_CAPT, WR_ISSUE, RESP} state_t;

  state_t      state, state_n;
  logic        accept;
  logic        misaligned;
  logic        wr_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;

  // Pick the addressed lane out of a RAM word and extend it to 32 bits.
  function automatic logic [31:0] extract_lane(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic        sgn,
                                               input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   extract_lane = sgn ? {{24{b[7]}}, b} : {24'h0, b};
      2'b01:   extract_lane = sgn ? {{16{h[15]}}, h} : {16'h0, h};
      default: extract_lane = word;
    endcase
  endfunction

  // Overlay the store lane onto the old word; all other lanes are preserved.
  function automatic logic [31:0] merge_lane(input logic [31:0] old,
                                             input logic [15:0] wd,
                                             input logic [1:0]  size,
                                             input logic [1:0]  lane);
    merge_lane = old;
    if (size == 2'b00)
      merge_lane[{lane, 3'b000} +: 8] = wd[7:0];
    else
      merge_lane[{lane[1], 4'b0000} +: 16] = wd;
  endfunction

  assign accept = bus.req_valid & bus.req_ready;

`ifdef LSU_ALIGN_CHECK_EN
  assign misaligned = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                      (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Control outputs are decoded from state and gated off during reset.
  assign bus.req_ready = !reset && (state == IDLE);
  assign ram_enable    = !reset && ((state == RD_ISSUE) || (state == WR_ISSUE));
  assign write_enable  = !reset && (state == WR_ISSUE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (misaligned)                          state_n = RESP;
          else if (bus.req_write && bus.req_size[1]) state_n = WR_ISSUE;
          else                                     state_n = RD_ISSUE;
        end
      end
      RD_ISSUE: state_n = RD_CAPT;
      RD_CAPT:  state_n = wr_q ? WR_ISSUE : RESP;
      WR_ISSUE: state_n = RESP;
      RESP:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // Request capture at accept; read data is consumed in RD_CAPT either as the
  // load result or as the base word of a read-modify-write.
  always_ff @(posedge clock) begin
    if (accept) begin
      wr_q     <= bus.req_write;
      size_q   <= bus.req_size;
      signed_q <= bus.req_signed;
      lane_q   <= bus.req_addr[1:0];
      wdata_q  <= bus.req_wdata[15:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      ram_address  <= '0;
      ram_in_data  <= '0;
    end else begin
      resp_valid_q <= (state_n == RESP);
      if (accept) begin
        ram_address <= bus.req_addr[ADDR_WIDTH-1:2];
        if (bus.req_write && bus.req_size[1])
          ram_in_data <= bus.req_wdata;
        if (misaligned)
          resp_rdata_q <= 32'h0;
      end
      if (state == RD_CAPT) begin
        if (wr_q) ram_in_data  <= merge_lane(ram_out_data, wdata_q, size_q, lane_q);
        else      resp_rdata_q <= extract_lane(ram_out_data, size_q, signed_q, lane_q);
      end
      if (state == WR_ISSUE)
        resp_rdata_q <= 32'h0;
    end
  end

`ifdef LSU_ALIGN_CHECK_EN
  logic resp_error_q;

  // Error flag is set only on the direct IDLE->RESP path and cleared by any
  // normal completion, so it holds between responses.
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_error_q <= 1'b0;
    end else begin
      if (accept && misaligned)              resp_error_q <= 1'b1;
      else if (state_n == RESP && !accept)   resp_error_q <= 1'b0;
    end
  end

  assign bus.resp_error = resp_error_q;
`else
  assign bus.resp_error = 1'b0;
`endif

endmodule

// File: tb/tb_bram_lsu.sv
module tb_bram_lsu;

  logic        clock;
  logic        reset;
  logic        ram_enable;
  logic        write_enable;
  logic [8:0]  ram_address;
  logic [31:0] ram_in_data;
  logic [31:0] ram_out_data;

  logic [31:0] mem [0:511];

  int tests;
  int fails;
  int we_cnt;
  int en_cnt;
  int idle_en_viol;
  logic [8:0]  we_addr;

  bram_lsu_if #(.ADDR_WIDTH(11)) bus ();

  bram_lsu #(.RAM_WIDTH(32), .RAM_ADDR_BITS(9), .ADDR_WIDTH(11)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .ram_enable   (ram_enable),
    .write_enable (write_enable),
    .ram_address  (ram_address),
    .ram_in_data  (ram_in_data),
    .ram_out_data (ram_out_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single-port RAM with registered read.
  always @(posedge clock) begin
    if (ram_enable) begin
      if (write_enable) mem[ram_address] <= ram_in_data;
      ram_out_data <= mem[ram_address];
    end
  end

  // Port activity monitor.
  always @(negedge clock) begin
    if (write_enable) begin
      we_cnt  <= we_cnt + 1;
      we_addr <= ram_address;
    end
    if (ram_enable) en_cnt <= en_cnt + 1;
    if (bus.req_ready && ram_enable) idle_en_viol <= idle_en_viol + 1;
  end

  // One request from a negedge; returns at the negedge where resp_valid is seen.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [10:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    rd  = 32'hx;
    er  = 1'bx;
    lat = 0;
    for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clock);
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
    bus.req_wdata = 32'h0;
    for (int i = 1; i <= 10; i++) begin
      if (bus.resp_valid) begin
        lat = i;
        rd  = bus.resp_rdata;
        er  = bus.resp_error;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_size = 2'b10;
    bus.req_signed = 1'b0;
    bus.req_addr = 11'h010;
    bus.req_wdata = 32'h0;
    repeat (3) @(negedge clock);
    tests++;
    if (bus.req_ready !== 1'b0 || ram_enable !== 1'b0 || write_enable !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: ready=%b en=%b we=%b required 0 0 0", bus.req_ready, ram_enable, write_enable);
    end
    tests++;
    if (bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'h0 || bus.resp_error !== 1'b0) begin
      fails++;
      $display("FAIL reset_resp: valid=%b rdata=%h err=%b required 0 0 0", bus.resp_valid, bus.resp_rdata, bus.resp_error);
    end
    tests++;
    if (ram_address !== 9'h0 || ram_in_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_ram: addr=%h data=%h required 0 0", ram_address, ram_in_data);
    end
    bus.req_valid = 1'b0;
    reset = 1'b0;
    #1;
    tests++;
    if (bus.req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b required 1", bus.req_ready);
    end
    @(negedge clock);
  endtask

  task automatic test_word;
    logic [31:0] rd; logic er; int lat; int we0;
    we0 = we_cnt;
    do_req(1'b1, 2'b10, 1'b0, 11'h010, 32'hDEADBEEF, rd, er, lat);
    tests++;
    if (lat !== 2 || rd !== 32'h0) begin
      fails++;
      $display("FAIL word_store: lat=%0d rdata=%h required 2 00000000", lat, rd);
    end
    tests++;
    if (we_cnt - we0 !== 1 || we_addr !== 9'd4 || mem[4] !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL word_store_ram: we=%0d addr=%0d mem=%h required 1 4 deadbeef", we_cnt - we0, we_addr, mem[4]);
    end
    do_req(1'b0, 2'b10, 1'b0, 11'h010, 32'h0, rd, er, lat);
    tests++;
    if (lat !== 3 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
      fails++;
      $display("FAIL word_load: lat=%0d rdata=%h err=%b required 3 deadbeef 0", lat, rd, er);
    end
  endtask

  task automatic test_byte;
    logic [31:0] rd; logic er; int lat; int we0;
    we0 = we_cnt;
    do_req(1'b1, 2'b00, 1'b0, 11'h013, 32'h000000A5, rd, er, lat);
    tests++;
    if (lat !== 4 || we_cnt - we0 !== 1 || mem[4] !== 32'hA5ADBEEF) begin
      fails++;
      $display("FAIL byte_store: lat=%0d we=%0d mem=%h required 4 1 a5adbeef", lat, we_cnt - we0, mem[4]);
    end
    do_req(1'b0, 2'b00, 1'b1, 11'h013, 32'h0, rd, er, lat);
    tests++;
    if (lat !== 3 || rd !== 32'hFFFFFFA5) begin
      fails++;
      $display("FAIL byte_load_s: lat=%0d rdata=%h required 3 ffffffa5", lat, rd);
    end
    do_req(1'b0, 2'b00, 1'b0, 11'h013, 32'h0, rd, er, lat);
    tests++;
    if (rd !== 32'h000000A5) begin
      fails++;
      $display("FAIL byte_load_u: rdata=%h required 000000a5", rd);
    end
  endtask

  task automatic test_half;
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 2'b01, 1'b0, 11'h010, 32'h00008001, rd, er, lat);
    tests++;
    if (lat !== 4 || mem[4] !== 32'hA5AD8001) begin
      fails++;
      $display("FAIL half_store: lat=%0d mem=%h required 4 a5ad8001", lat, mem[4]);
    end
    do_req(1'b0, 2'b01, 1'b1, 11'h010, 32'h0, rd, er, lat);
    tests++;
    if (rd !== 32'hFFFF8001) begin
      fails++;
      $display("FAIL half_load_s: rdata=%h required ffff8001", rd);
    end
    do_req(1'b0, 2'b01, 1'b0, 11'h012, 32'h0, rd, er, lat);
    tests++;
    if (rd !== 32'h0000A5AD) begin
      fails++;
      $display("FAIL half_load_u: rdata=%h required 0000a5ad", rd);
    end
  endtask

  task automatic test_lanes;
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 2'b10, 1'b0, 11'h018, 32'h11223344, rd, er, lat);
    do_req(1'b1, 2'b00, 1'b0, 11'h019, 32'hFFFFFF5A, rd, er, lat);
    tests++;
    if (mem[6] !== 32'h11225A44) begin
      fails++;
      $display("FAIL lane1_store: mem=%h required 11225a44", mem[6]);
    end
    do_req(1'b0, 2'b00, 1'b0, 11'h019, 32'h0, rd, er, lat);
    tests++;
    if (rd !== 32'h0000005A) begin
      fails++;
      $display("FAIL lane1_load: rdata=%h required 0000005a", rd);
    end
    do_req(1'b0, 2'b01, 1'b1, 11'h01A, 32'h0, rd, er, lat);
    tests++;
    if (rd !== 32'h00001122) begin
      fails++;
      $display("FAIL upper_half_load: rdata=%h required 00001122", rd);
    end
    do_req(1'b0, 2'b00, 1'b1, 11'h018, 32'h0, rd, er, lat);
    tests++;
    if (rd !== 32'h00000044) begin
      fails++;
      $display("FAIL lane0_load: rdata=%h required 00000044", rd);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd; logic er; int lat;
    logic [31:0] exp_q [0:4];
    int accepted; int resps; int extra;
    for (int i = 0; i < 5; i++) begin
      exp_q[i] = 32'hC0DE0000 + 32'(i * 17);
      do_req(1'b1, 2'b10, 1'b0, 11'(11'h020 + 4 * i), exp_q[i], rd, er, lat);
    end
    accepted = 0;
    resps = 0;
    extra = 0;
    for (int c = 0; c < 60 && resps < 5; c++) begin
      @(negedge clock);
      if (bus.resp_valid) begin
        tests++;
        if (bus.resp_rdata !== exp_q[resps]) begin
          fails++;
          $display("FAIL b2b_data%0d: rdata=%h required %h", resps, bus.resp_rdata, exp_q[resps]);
        end
        resps++;
      end
      if (accepted < 5) begin
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b0;
        bus.req_size   = 2'b10;
        bus.req_signed = 1'b0;
        bus.req_addr   = 11'(11'h020 + 4 * accepted);
      end else begin
        bus.req_valid = 1'b0;
      end
      if (bus.req_valid && bus.req_ready) accepted++;
    end
    bus.req_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (bus.resp_valid) extra++;
    end
    tests++;
    if (accepted !== 5 || resps !== 5 || extra !== 0) begin
      fails++;
      $display("FAIL b2b_count: accepts=%0d resps=%0d extra=%0d required 5 5 0", accepted, resps, extra);
    end
    tests++;
    if (idle_en_viol !== 0) begin
      fails++;
      $display("FAIL idle_enable: count=%0d required 0", idle_en_viol);
    end
  endtask

  task automatic test_reset_abort;
    int we0; int resp_seen;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 11'h010;
    bus.req_wdata  = 32'h00000077;
    for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clock);
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
    @(negedge clock);
    we0 = we_cnt;
    reset = 1'b1;
    #1;
    tests++;
    if (ram_enable !== 1'b0 || bus.req_ready !== 1'b0) begin
      fails++;
      $display("FAIL abort_gating: en=%b ready=%b required 0 0", ram_enable, bus.req_ready);
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    tests++;
    if (bus.req_ready !== 1'b1) begin
      fails++;
      $display("FAIL abort_ready: got %b required 1", bus.req_ready);
    end
    resp_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (bus.resp_valid) resp_seen++;
    end
    tests++;
    if (we_cnt !== we0 || resp_seen !== 0 || mem[4] !== 32'hA5AD8001) begin
      fails++;
      $display("FAIL abort_effects: we=%0d resp=%0d mem=%h required 0 0 a5ad8001", we_cnt - we0, resp_seen, mem[4]);
    end
  endtask

  task automatic test_misaligned;
    logic [31:0] rd; logic er; int lat; int en0;
    en0 = en_cnt;
    do_req(1'b0, 2'b01, 1'b0, 11'h011, 32'h0, rd, er, lat);
`ifdef LSU_ALIGN_CHECK_EN
    tests++;
    if (lat !== 1 || rd !== 32'h0 || er !== 1'b1 || en_cnt !== en0) begin
      fails++;
      $display("FAIL misaligned_half: lat=%0d rdata=%h err=%b en=%0d required 1 00000000 1 0", lat, rd, er, en_cnt - en0);
    end
    do_req(1'b0, 2'b10, 1'b0, 11'h010, 32'h0, rd, er, lat);
    tests++;
    if (er !== 1'b0 || rd !== 32'hA5AD8001) begin
      fails++;
      $display("FAIL err_clear: rdata=%h err=%b required a5ad8001 0", rd, er);
    end
`else
    tests++;
    if (lat !== 3 || rd !== 32'h00008001 || er !== 1'b0 || en_cnt - en0 !== 1) begin
      fails++;
      $display("FAIL misaligned_half: lat=%0d rdata=%h err=%b en=%0d required 3 00008001 0 1", lat, rd, er, en_cnt - en0);
    end
`endif
  endtask

  initial begin
    tests = 0;
    fails = 0;
    we_cnt = 0;
    en_cnt = 0;
    idle_en_viol = 0;
    we_addr = 9'h0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_lanes();
    test_back_to_back();
    test_reset_abort();
    test_misaligned();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
